control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Fetch/decode/execute sequencer for the 16-bit CPU. Sits directly upstream of datapath.
//  Drives every datapath select (`SELECT_* codes, 5-bit) plus AluOp and Imm.
//  Owns the memory-bus read/write strobes and the MemAck handshake.
// PARAMETERS
//  WAIT_LIMIT  255   max cycles a MemRd/MemWr may wait for MemAck before bus error (1..65535)
//  ALU_PASS_A  4'h0  AluOp code that makes the ALU output RegA unchanged
// PORTS
//  Clk         in   1   clock, rising edge
//  Rst         in   1   reset, asynchronous, active-high
//  MemData     in   16  memory read data; valid while MemAck=1
//  MemAck      in   1   memory access complete, sampled on Clk
//  MemRd       out  1   read strobe; address is datapath RegMemAddr
//  MemWr       out  1   write strobe; address/data are datapath RegMemAddr/RegMemData
//  SrcIP, SrcMemAddr, SrcMemData, SrcSP, SrcFlags, SrcA, SrcB  out 5 each  datapath selects
//  AluOp       out  4   ALU operation
//  Imm         out  16  {4'h0, IR[11:0]}, combinational from instruction register
//  Halted      out  1   core stopped (HALT, bus error or trap)
//  BusErr      out  1   sticky; set on MemAck timeout
//  Trap        out  1   sticky; illegal-opcode trap (constant 0 without ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  Reset: state=FETCH, IR=0, wait counter=0, Halted=BusErr=Trap=0, MemRd=MemWr=0.
//   All outputs are decoded from state/IR. Every select not listed below = `SELECT_NONE.
//   AluOp defaults to ALU_PASS_A.
//  Instr: IR[15:12] opcode, IR[11:0] imm12.
//   Stack: SP points at next free word. Push writes then decrements; pop increments then reads.
//  States: FETCH, FWAIT, EXEC1, EXEC2, MWAIT, HALT.
//  FETCH: SrcMemAddr=`SELECT_IP -> FWAIT.
//  FWAIT: MemRd=1 until MemAck. On ack: IR<=MemData, SrcIP=`SELECT_INC -> EXEC1.
//  Opcodes, as EXEC1 / EXEC2 / MWAIT actions:
//   0 NOP   : EXEC1 -> FETCH.
//   1 PUSHI : EXEC1 SrcMemData=IMM, SrcMemAddr=SP; MWAIT MemWr=1; on ack SrcSP=DEC.
//   2 POPA  : EXEC1 SrcSP=INC; EXEC2 SrcMemAddr=SP; MWAIT MemRd=1; on ack SrcA=MEM.
//   3 POPB  : as POPA, but the ack cycle sets SrcB=MEM.
//   4 ALU   : EXEC1 AluOp=imm12[3:0], SrcA=`SELECT_ALU, SrcFlags=`SELECT_ALU -> FETCH.
//   5 PUSHA : EXEC1 AluOp=ALU_PASS_A, SrcMemData=ALU, SrcMemAddr=SP; MWAIT MemWr=1; ack SrcSP=DEC.
//   6 LDA   : EXEC1 SrcMemAddr=IP; MWAIT MemRd=1; on ack SrcA=MEM, SrcIP=INC (skips literal).
//   F HALT  : -> HALT.
//   others  : see CONFIGURATION.
//  Flow: opcodes with no EXEC2 go EXEC1 -> MWAIT. MWAIT -> FETCH on ack.
//  Latency: NOP/ALU = 3 cycles plus fetch wait. Memory ops = 4-5 cycles plus waits.
//  Zero-wait memory (ack same cycle as strobe) gives the minimum.
//  HALT: all strobes 0, all selects NONE, Halted=1. Left only by Rst.
//  Wait counter: cleared on entering FWAIT/MWAIT, increments each cycle with no ack.
//   Reaching WAIT_LIMIT without ack: BusErr<=1, strobe drops, -> HALT.
//   Ack on the same cycle the limit is reached wins (no error).
//  MemAck while no strobe is asserted: ignored.
//  Rst mid-transaction: strobes drop asynchronously; pending access abandoned.
//  IP/SP wrap is the datapath's modulo-2^16 arithmetic; no special handling here.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: opcodes 7..E in EXEC1 set Trap<=1 and go -> HALT.
//  ILLEGAL_TRAP_EN undefined: opcodes 7..E execute as NOP; Trap tied 0.
// TESTING
//  1 Rst pulse mid-FWAIT -> MemRd=0 immediately; after release, first fetch at address 0.
//  2 Mem[0]=0x1ABC, 0-wait, SP=0 -> MemWr once, RegMemData=0x0ABC at addr 0, SP=0xFFFF.
//    Mem[1]=0x2000 -> SP=0x0000, RegA=0x0ABC.
//  3 Mem[0]=0x6000, Mem[1]=0x1234, Mem[2]=0xF000 -> RegA=0x1234, IP=3, Halted=1.
//    No further MemRd after halt.
//  4 Mem[0]=0x4003 -> AluOp=3 for exactly one cycle, SrcA and SrcFlags=`SELECT_ALU, next state FETCH.
//  5 MemAck withheld, WAIT_LIMIT=4 -> BusErr=1, Halted=1 after 4 wait cycles.
//    Same run with ack at cycle 4 -> no BusErr.
//  6 Mem[0]=0x7000 -> with ILLEGAL_TRAP_EN: Trap=1, Halted=1.
//    Without: next fetch from addr 1, Trap=0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 16-bit CPU.
// Optional macro ILLEGAL_TRAP_EN: opcodes 7..E trap and halt instead of acting as NOP.

`ifndef SELECT_NONE
`define SELECT_NONE 5'd0
`endif
`ifndef SELECT_IP
`define SELECT_IP   5'd1
`endif
`ifndef SELECT_SP
`define SELECT_SP   5'd2
`endif
`ifndef SELECT_INC
`define SELECT_INC  5'd3
`endif
`ifndef SELECT_DEC
`define SELECT_DEC  5'd4
`endif
`ifndef SELECT_IMM
`define SELECT_IMM  5'd5
`endif
`ifndef SELECT_MEM
`define SELECT_MEM  5'd6
`endif
`ifndef SELECT_ALU
`define SELECT_ALU  5'd7
`endif

module control_unit #(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter logic [3:0]  ALU_PASS_A = 4'h0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] MemData,
  input  logic        MemAck,
  output logic        MemRd,
  output logic        MemWr,
  output logic [4:0]  SrcIP,
  output logic [4:0]  SrcMemAddr,
  output logic [4:0]  SrcMemData,
  output logic [4:0]  SrcSP,
  output logic [4:0]  SrcFlags,
  output logic [4:0]  SrcA,
  output logic [4:0]  SrcB,
  output logic [3:0]  AluOp,
  output logic [15:0] Imm,
  output logic        Halted,
  output logic        BusErr,
  output logic        Trap
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_FWAIT,
    S_EXEC1,
    S_EXEC2,
    S_MWAIT,
    S_HALT
  } state_t;

  localparam logic [15:0] LAST_WAIT = 16'(WAIT_LIMIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [15:0] r_wait;
  logic        r_bus_err;

  logic [3:0]  w_op;
  logic        w_nop;
  logic        w_pushi;
  logic        w_popa;
  logic        w_popb;
  logic        w_alu;
  logic        w_pusha;
  logic        w_lda;
  logic        w_halt;
  logic        w_ill;
  logic        w_mem_wr;
  logic        w_mem_rd;
  logic        w_at_limit;

  logic        w_ir_ld;
  logic        w_wait_clr;
  logic        w_wait_inc;
  logic        w_bus_err_set;
`ifdef ILLEGAL_TRAP_EN
  logic        w_trap_set;
  logic        r_trap;
`endif

  assign w_op    = r_ir[15:12];
  assign w_nop   = (w_op == 4'h0);
  assign w_pushi = (w_op == 4'h1);
  assign w_popa  = (w_op == 4'h2);
  assign w_popb  = (w_op == 4'h3);
  assign w_alu   = (w_op == 4'h4);
  assign w_pusha = (w_op == 4'h5);
  assign w_lda   = (w_op == 4'h6);
  assign w_halt  = (w_op == 4'hF);
  assign w_ill   = (w_op >= 4'h7) && (w_op <= 4'hE);

  assign w_mem_wr   = w_pushi | w_pusha;
  assign w_mem_rd   = w_popa | w_popb | w_lda;
  assign w_at_limit = (r_wait == LAST_WAIT);

  assign Imm    = {4'h0, r_ir[11:0]};
  assign Halted = (r_state == S_HALT);
  assign BusErr = r_bus_err;
`ifdef ILLEGAL_TRAP_EN
  assign Trap   = r_trap;
`else
  assign Trap   = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_ld)
        r_ir <= MemData;
      if (w_wait_clr)
        r_wait <= '0;
      else if (w_wait_inc)
        r_wait <= r_wait + 16'd1;
      if (w_bus_err_set)
        r_bus_err <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      r_trap <= 1'b0;
    else if (w_trap_set)
      r_trap <= 1'b1;
  end
`endif

  always_comb begin
    w_next        = r_state;
    MemRd         = 1'b0;
    MemWr         = 1'b0;
    SrcIP         = `SELECT_NONE;
    SrcMemAddr    = `SELECT_NONE;
    SrcMemData    = `SELECT_NONE;
    SrcSP         = `SELECT_NONE;
    SrcFlags      = `SELECT_NONE;
    SrcA          = `SELECT_NONE;
    SrcB          = `SELECT_NONE;
    AluOp         = ALU_PASS_A;
    w_ir_ld       = 1'b0;
    w_wait_clr    = 1'b0;
    w_wait_inc    = 1'b0;
    w_bus_err_set = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    w_trap_set    = 1'b0;
`endif

    unique case (r_state)
      S_FETCH: begin
        SrcMemAddr = `SELECT_IP;
        w_wait_clr = 1'b1;
        w_next     = S_FWAIT;
      end

      S_FWAIT: begin
        MemRd = 1'b1;
        if (MemAck) begin
          w_ir_ld = 1'b1;
          SrcIP   = `SELECT_INC;
          w_next  = S_EXEC1;
        end else if (w_at_limit) begin
          w_bus_err_set = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_EXEC1: begin
        unique case (1'b1)
          w_nop: w_next = S_FETCH;
          w_pushi: begin
            SrcMemData = `SELECT_IMM;
            SrcMemAddr = `SELECT_SP;
            w_wait_clr = 1'b1;
            w_next     = S_MWAIT;
          end
          w_popa, w_popb: begin
            SrcSP  = `SELECT_INC;
            w_next = S_EXEC2;
          end
          w_alu: begin
            AluOp    = r_ir[3:0];
            SrcA     = `SELECT_ALU;
            SrcFlags = `SELECT_ALU;
            w_next   = S_FETCH;
          end
          w_pusha: begin
            AluOp      = ALU_PASS_A;
            SrcMemData = `SELECT_ALU;
            SrcMemAddr = `SELECT_SP;
            w_wait_clr = 1'b1;
            w_next     = S_MWAIT;
          end
          w_lda: begin
            // literal word sits right after the opcode; IP already points at it
            SrcMemAddr = `SELECT_IP;
            w_wait_clr = 1'b1;
            w_next     = S_MWAIT;
          end
          w_halt: w_next = S_HALT;
          w_ill: begin
`ifdef ILLEGAL_TRAP_EN
            w_trap_set = 1'b1;
            w_next     = S_HALT;
`else
            w_next     = S_FETCH;
`endif
          end
          default: w_next = S_FETCH;
        endcase
      end

      S_EXEC2: begin
        SrcMemAddr = `SELECT_SP;
        w_wait_clr = 1'b1;
        w_next     = S_MWAIT;
      end

      S_MWAIT: begin
        MemRd = w_mem_rd;
        MemWr = w_mem_wr;
        if (MemAck) begin
          w_next = S_FETCH;
          unique case (1'b1)
            w_mem_wr: SrcSP = `SELECT_DEC;
            w_popa:   SrcA  = `SELECT_MEM;
            w_popb:   SrcB  = `SELECT_MEM;
            w_lda: begin
              SrcA  = `SELECT_MEM;
              SrcIP = `SELECT_INC;
            end
            default: ;
          endcase
        end else if (w_at_limit) begin
          w_bus_err_set = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_HALT: w_next = S_HALT;

      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives control_unit with a behavioural datapath and memory,
// comparing final architectural state against an instruction-level model.

`ifndef SELECT_NONE
`define SELECT_NONE 5'd0
`endif
`ifndef SELECT_IP
`define SELECT_IP   5'd1
`endif
`ifndef SELECT_SP
`define SELECT_SP   5'd2
`endif
`ifndef SELECT_INC
`define SELECT_INC  5'd3
`endif
`ifndef SELECT_DEC
`define SELECT_DEC  5'd4
`endif
`ifndef SELECT_IMM
`define SELECT_IMM  5'd5
`endif
`ifndef SELECT_MEM
`define SELECT_MEM  5'd6
`endif
`ifndef SELECT_ALU
`define SELECT_ALU  5'd7
`endif

module tb_control_unit;

  localparam int WL = 4;

  localparam int M_RAND  = 0;
  localparam int M_ZERO  = 1;
  localparam int M_NEVER = 2;
  localparam int M_LATE  = 3;
  localparam int M_NOWR  = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] MemData;
  logic        MemAck;
  logic        MemRd, MemWr;
  logic [4:0]  SrcIP, SrcMemAddr, SrcMemData, SrcSP, SrcFlags, SrcA, SrcB;
  logic [3:0]  AluOp;
  logic [15:0] Imm;
  logic        Halted, BusErr, Trap;

  control_unit #(.WAIT_LIMIT(WL), .ALU_PASS_A(4'h0)) dut (
    .Clk(Clk), .Rst(Rst), .MemData(MemData), .MemAck(MemAck),
    .MemRd(MemRd), .MemWr(MemWr),
    .SrcIP(SrcIP), .SrcMemAddr(SrcMemAddr), .SrcMemData(SrcMemData),
    .SrcSP(SrcSP), .SrcFlags(SrcFlags), .SrcA(SrcA), .SrcB(SrcB),
    .AluOp(AluOp), .Imm(Imm), .Halted(Halted), .BusErr(BusErr), .Trap(Trap)
  );

  initial forever #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] image [0:65535];
  logic [15:0] mem   [0:65535];
  logic [15:0] mmem  [0:65535];

  logic [15:0] ip, sp, ra, rb, rmaddr, rmdata, sp_init;
  logic        fz;
  logic [15:0] alu_y, n_ip, n_sp, n_a, n_b, n_ma, n_md;
  logic        n_fz;
  int          rd_cnt, wr_cnt, rd_hi, alu3_cnt, alu3_sel;
  logic [15:0] last_wa, last_wd, first_rd_addr;
  logic        first_rd_seen;

  int          ack_mode = M_ZERO;
  bit          noise = 1'b0;
  int          waited, delay;

  function automatic logic [15:0] alu_f(input logic [3:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h3:    return a & b;
      4'h4:    return a | b;
      4'h5:    return a ^ b;
      4'h6:    return ~a;
      4'h7:    return a << 1;
      default: return a;
    endcase
  endfunction

  // behavioural datapath and memory write port
  initial forever begin
    @(posedge Clk or posedge Rst);
    if (Rst) begin
      for (int i = 0; i < 65536; i++) mem[i] = image[i];
      ip = 0; sp = sp_init; ra = 0; rb = 0; fz = 0;
      rmaddr = 0; rmdata = 0;
      rd_cnt = 0; wr_cnt = 0; rd_hi = 0; alu3_cnt = 0; alu3_sel = 0;
      last_wa = 16'hDEAD; last_wd = 16'hDEAD;
      first_rd_addr = 16'hDEAD; first_rd_seen = 0;
    end else begin
      alu_y = alu_f(AluOp, ra, rb);
      if (MemRd) rd_hi++;
      if (AluOp == 4'h3) begin
        alu3_cnt++;
        if (SrcA == `SELECT_ALU && SrcFlags == `SELECT_ALU) alu3_sel++;
      end
      if (MemRd && MemAck) begin
        rd_cnt++;
        if (!first_rd_seen) begin
          first_rd_seen = 1; first_rd_addr = rmaddr;
        end
      end
      if (MemWr && MemAck) begin
        mem[rmaddr] = rmdata; wr_cnt++;
        last_wa = rmaddr; last_wd = rmdata;
      end
      n_ip = (SrcIP == `SELECT_INC) ? ip + 16'd1 : ip;
      n_sp = (SrcSP == `SELECT_INC) ? sp + 16'd1 :
             (SrcSP == `SELECT_DEC) ? sp - 16'd1 : sp;
      n_ma = (SrcMemAddr == `SELECT_IP) ? ip :
             (SrcMemAddr == `SELECT_SP) ? sp : rmaddr;
      n_md = (SrcMemData == `SELECT_IMM) ? Imm :
             (SrcMemData == `SELECT_ALU) ? alu_y : rmdata;
      n_a  = (SrcA == `SELECT_MEM) ? MemData :
             (SrcA == `SELECT_ALU) ? alu_y : ra;
      n_b  = (SrcB == `SELECT_MEM) ? MemData : rb;
      n_fz = (SrcFlags == `SELECT_ALU) ? (alu_y == 16'd0) : fz;
      ip = n_ip; sp = n_sp; rmaddr = n_ma; rmdata = n_md;
      ra = n_a; rb = n_b; fz = n_fz;
    end
  end

  // memory responder: ack timing per mode, random ack noise while idle
  initial begin
    MemAck = 0; MemData = 0; waited = 0; delay = 0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        MemAck = 0; waited = 0;
      end else if (MemRd || MemWr) begin
        if (waited == 0)
          case (ack_mode)
            M_RAND:  delay = $urandom_range(0, WL - 1);
            M_LATE:  delay = WL - 1;
            M_NEVER: delay = 1 << 20;
            M_NOWR:  delay = MemWr ? (1 << 20) : 0;
            default: delay = 0;
          endcase
        MemAck  = (waited == delay);
        MemData = mem[rmaddr];
        waited++;
      end else begin
        waited  = 0;
        MemAck  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        MemData = 16'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 65536; i++) image[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1;
    #2;
    Rst = 0;
  endtask

  task automatic wait_halt(input int budget, output int cyc);
    cyc = 0;
    while (!Halted && cyc < budget) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    chk("halt_reached", 32'(Halted), 32'd1);
  endtask

  function automatic logic [31:0] hash_mem(input bit mdl);
    logic [31:0] h;
    logic [15:0] w;
    logic [15:0] a;
    h = 0;
    for (int i = 0; i < 64; i++) begin
      w = mdl ? mmem[i] : mem[i];
      h = h * 31 + 32'(w);
    end
    for (int i = -40; i <= 40; i++) begin
      a = sp_init + 16'(i);
      w = mdl ? mmem[a] : mem[a];
      h = h * 31 + 32'(w);
    end
    return h;
  endfunction

  // instruction-level reference: one loop iteration per instruction
  task automatic model_run(output logic [15:0] e_ip, output logic [15:0] e_sp,
                           output logic [15:0] e_a, output logic [15:0] e_b,
                           output logic e_fz, output int e_rd, output int e_wr,
                           output logic e_trap);
    logic [15:0] ir, imm, y;
    logic [3:0]  op;
    for (int i = 0; i < 65536; i++) mmem[i] = image[i];
    e_ip = 0; e_sp = sp_init; e_a = 0; e_b = 0; e_fz = 0;
    e_rd = 0; e_wr = 0; e_trap = 0;
    for (int s = 0; s < 400; s++) begin
      ir = mmem[e_ip]; e_rd++; e_ip++;
      op = ir[15:12]; imm = {4'h0, ir[11:0]};
      if (op == 4'hF) break;
      case (op)
        4'h0: ;
        4'h1: begin mmem[e_sp] = imm; e_wr++; e_sp--; end
        4'h2: begin e_sp++; e_rd++; e_a = mmem[e_sp]; end
        4'h3: begin e_sp++; e_rd++; e_b = mmem[e_sp]; end
        4'h4: begin y = alu_f(ir[3:0], e_a, e_b); e_a = y; e_fz = (y == 0); end
        4'h5: begin mmem[e_sp] = e_a; e_wr++; e_sp--; end
        4'h6: begin e_a = mmem[e_ip]; e_rd++; e_ip++; end
        default: begin
`ifdef ILLEGAL_TRAP_EN
          e_trap = 1;
          break;
`endif
        end
      endcase
    end
  endtask

  int          cyc, snap;
  logic [15:0] e_ip, e_sp, e_a, e_b;
  logic        e_fz, e_trap;
  int          e_rd, e_wr, plen, kind;
  logic [15:0] w;

  initial begin
    sp_init = 16'h0000;
    clear_image();

    // reset state and async strobe drop mid-FWAIT
    image[0] = 16'hF000;
    ack_mode = M_NEVER;
    @(negedge Clk);
    Rst = 1;
    #1;
    chk("rst_memrd", 32'(MemRd), 0);
    chk("rst_memwr", 32'(MemWr), 0);
    chk("rst_halted", 32'(Halted), 0);
    chk("rst_buserr", 32'(BusErr), 0);
    chk("rst_trap", 32'(Trap), 0);
    chk("rst_imm", 32'(Imm), 0);
    chk("rst_aluop", 32'(AluOp), 0);
    chk("rst_fetch_sel", 32'(SrcMemAddr), 32'(`SELECT_IP));
    chk("rst_srcA", 32'(SrcA), 32'(`SELECT_NONE));
    #1 Rst = 0;
    @(posedge Clk);
    #1;
    chk("fwait_memrd", 32'(MemRd), 1);
    #2 Rst = 1;
    #1;
    chk("rst_drops_memrd", 32'(MemRd), 0);
    ack_mode = M_ZERO;
    @(negedge Clk);
    #2 Rst = 0;
    wait_halt(200, cyc);
    chk("first_fetch_addr", 32'(first_rd_addr), 0);
    chk("halt_ip", 32'(ip), 1);

    // PUSHI with SP=0, then PUSHI+POPA
    clear_image();
    image[0] = 16'h1ABC; image[1] = 16'hF000;
    do_reset();
    wait_halt(200, cyc);
    chk("pushi_wr_cnt", 32'(wr_cnt), 1);
    chk("pushi_addr", 32'(last_wa), 0);
    chk("pushi_data", 32'(last_wd), 32'h0ABC);
    chk("pushi_sp", 32'(sp), 32'hFFFF);
    image[1] = 16'h2000; image[2] = 16'hF000;
    do_reset();
    wait_halt(200, cyc);
    chk("popa_sp", 32'(sp), 0);
    chk("popa_a", 32'(ra), 32'h0ABC);
    chk("push_pop_cycles", 32'(cyc), 12);

    // NOP latency
    clear_image();
    image[0] = 16'h0000; image[1] = 16'hF000;
    do_reset();
    wait_halt(200, cyc);
    chk("nop_cycles", 32'(cyc), 6);

    // LDA literal then HALT; no reads after halt
    image[0] = 16'h6000; image[1] = 16'h1234; image[2] = 16'hF000;
    do_reset();
    wait_halt(200, cyc);
    chk("lda_a", 32'(ra), 32'h1234);
    chk("lda_ip", 32'(ip), 3);
    chk("lda_reads", 32'(rd_cnt), 3);
    snap = rd_hi;
    repeat (10) @(posedge Clk);
    #1;
    chk("no_rd_after_halt", 32'(rd_hi), 32'(snap));
    chk("halt_sticky", 32'(Halted), 1);

    // ALU op drive
    clear_image();
    image[0] = 16'h4003; image[1] = 16'hF000;
    do_reset();
    wait_halt(200, cyc);
    chk("alu_op_cycles", 32'(alu3_cnt), 1);
    chk("alu_sel_cycles", 32'(alu3_sel), 1);
    chk("alu_cycles", 32'(cyc), 6);
    chk("alu_zero_flag", 32'(fz), 1);

    // bus error on fetch, limit boundary ack, bus error on write
    clear_image();
    image[0] = 16'h0000; image[1] = 16'hF000;
    ack_mode = M_NEVER;
    do_reset();
    wait_halt(200, cyc);
    chk("buserr_set", 32'(BusErr), 1);
    chk("buserr_wait_cycles", 32'(rd_hi), WL);
    chk("buserr_cycles", 32'(cyc), 32'(WL + 1));
    chk("buserr_memrd_low", 32'(MemRd), 0);
    ack_mode = M_LATE;
    do_reset();
    wait_halt(200, cyc);
    chk("late_ack_no_err", 32'(BusErr), 0);
    chk("late_ack_ip", 32'(ip), 2);
    chk("late_ack_cycles", 32'(cyc), 32'(2 * (WL + 2)));
    image[0] = 16'h1ABC;
    ack_mode = M_NOWR;
    do_reset();
    wait_halt(200, cyc);
    chk("wr_buserr", 32'(BusErr), 1);
    chk("wr_buserr_cycles", 32'(cyc), 32'(3 + WL));
    chk("wr_buserr_memwr_low", 32'(MemWr), 0);

    // illegal opcode
    clear_image();
    image[0] = 16'h7000; image[1] = 16'hF000;
    ack_mode = M_ZERO;
    do_reset();
    wait_halt(200, cyc);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_trap", 32'(Trap), 1);
    chk("ill_ip", 32'(ip), 1);
`else
    chk("ill_trap", 32'(Trap), 0);
    chk("ill_ip", 32'(ip), 2);
    chk("ill_reads", 32'(rd_cnt), 2);
`endif

    // random programs with random ack latency and idle ack noise
    sp_init  = 16'h8000;
    ack_mode = M_RAND;
    noise    = 1'b1;
    for (int p = 0; p < 12; p++) begin
      clear_image();
      for (int i = -40; i <= 40; i++)
        image[sp_init + 16'(i)] = 16'($urandom);
      plen = $urandom_range(6, 14);
      w = 0;
      for (int k = 0; k < plen; k++) begin
        kind = $urandom_range(0, 7);
        case (kind)
          0: image[w] = 16'h0000;
          1: image[w] = {4'h1, 12'($urandom)};
          2: image[w] = 16'h2000;
          3: image[w] = 16'h3000;
          4: image[w] = {4'h4, 8'($urandom), 4'($urandom_range(0, 7))};
          5: image[w] = 16'h5000;
          6: begin
            image[w] = 16'h6000; w++;
            image[w] = 16'($urandom);
          end
          default: image[w] = {4'($urandom_range(7, 14)), 12'($urandom)};
        endcase
        w++;
      end
      image[w] = 16'hF000;
      do_reset();
      wait_halt(3000, cyc);
      model_run(e_ip, e_sp, e_a, e_b, e_fz, e_rd, e_wr, e_trap);
      chk("rnd_ip", 32'(ip), 32'(e_ip));
      chk("rnd_sp", 32'(sp), 32'(e_sp));
      chk("rnd_a", 32'(ra), 32'(e_a));
      chk("rnd_b", 32'(rb), 32'(e_b));
      chk("rnd_flag", 32'(fz), 32'(e_fz));
      chk("rnd_reads", 32'(rd_cnt), 32'(e_rd));
      chk("rnd_writes", 32'(wr_cnt), 32'(e_wr));
      chk("rnd_trap", 32'(Trap), 32'(e_trap));
      chk("rnd_buserr", 32'(BusErr), 0);
      chk("rnd_mem", hash_mem(1'b0), hash_mem(1'b1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
